adc128s022_scan_ctrl: RTL
=========================

Name: adc128s022_scan_ctrl

Overview:
Parametrised multi-channel scan controller for the ADC128S022 8-channel 12-bit SPI ADC. It scans every channel enabled in a mask in one CS-low burst and drives the channel address on ADC_SADDR, accounting for the ADC's one-frame address-to-data pipeline. Each result is presented as a tagged 12-bit word with a one-cycle valid strobe. It supports single-shot and continuous modes and replaces the fixed single-frame driver in the sensor-reader path. All logic runs in the clk_in domain; no logic is clocked by ADC_SCLK.

Parameters:
CLK_DIV, 8, clk_in cycles per ADC_SCLK half-period; legal 2..255; 50 MHz/(2*8) = 3.125 MHz.
N_CH, 8, width of the ch_mask input; legal 1..8; bit i enables channel INi.
DATA_W, 12, result width; the lower DATA_W bits of each 16-bit frame are kept.

Ports:
clk_in  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  scan request; level-sampled in IDLE
continuous  in  1  1 = rescan back-to-back until cleared
ch_mask  in  N_CH  enabled channels; latched at scan start
ADC_SDAT  in  1  ADC DOUT
ADC_SCLK  out  1  SPI clock; idles high
ADC_CS_N  out  1  chip select, active low
ADC_SADDR  out  1  ADC DIN (address bits)
data_out  out  DATA_W  last conversion result
data_ch  out  3  channel number of data_out
data_valid  out  1  one-cycle strobe when data_out/data_ch update
busy  out  1  high from scan start until return to IDLE

Behaviour:
- Reset (async, immediate, including mid-frame): ADC_SCLK=1, ADC_CS_N=1, ADC_SADDR=0, data_out=0, data_ch=0, data_valid=0, busy=0, state=IDLE, all counters=0.
- States: IDLE, CS_SETUP, SCLK_LO, SCLK_HI, CS_HOLD.
- IDLE: if start=1 and ch_mask!=0, latch ch_mask into mask_r and continuous into cont_r, build the ordered list of enabled channels (ascending), set M = popcount(mask_r), go to CS_SETUP. start with mask=0 is ignored. start outside IDLE is ignored.
- CS_SETUP: CS_N=0, SCLK=1 for CLK_DIV cycles, then SCLK_LO (frame 0, bit 0).
- Each frame has 16 bits; each bit is SCLK_LO for CLK_DIV cycles followed by SCLK_HI for CLK_DIV cycles.
  - SADDR changes only on entry to SCLK_LO.
  - ADC_SDAT is shifted into a 16-bit register on the clk_in edge that enters SCLK_HI.
- SADDR content per frame: bits 2,3,4 (0-based, MSB first) carry ADD2, ADD1, ADD0. All other bits are 0.
  - Frame f (0..M-1) addresses the f-th enabled channel.
  - Frame M re-sends the last enabled address.
- Scan length: M+1 frames with CS held low throughout; no SCLK gap between frames.
- Results:
  - Frame 0 data is discarded.
  - At the end of frame f≥1: data_out <= shift[DATA_W-1:0], data_ch <= channel addressed in frame f-1, data_valid=1 for exactly one clk_in cycle. This occurs on the cycle after the 16th SCLK_HI phase completes.
- After the last frame: CS_HOLD with CS_N=1, SCLK=1 for CLK_DIV cycles.
  - If cont_r=1 and the continuous input is still 1: relatch ch_mask and go to CS_SETUP. A mask of 0 at relatch ends the scan to IDLE.
  - Otherwise go to IDLE; busy falls on entry to IDLE.
- Total CS-low time per scan: CLK_DIV + (M+1)*32*CLK_DIV clk_in cycles.
- ch_mask and continuous changes mid-scan have no effect until the next latch point.
- M=1: two frames, one result.

Test Plan:
1. Reset: assert reset for 3 cycles, then drive start=1 → all outputs hold their reset values during reset; after release, outputs stay at reset values until a scan starts.
2. Single scan (CLK_DIV=2, ch_mask=8'h05). ADC model returns 0x0A5C for IN0 and 0x03F1 for IN2 (address pipelined by one frame).
   - SADDR address bits are 000, 010, 010 across the three frames.
   - CS_N is low for 194 cycles.
   - Exactly two data_valid pulses: (ch0, 0xA5C) then (ch2, 0x3F1).
   - busy returns to 0.
3. start=1 with ch_mask=0 → CS_N, SCLK and busy stay high/high/low for 100 cycles; no data_valid.
4. continuous=1, ch_mask=8'h80 → repeated 2-frame scans with CS_N high for exactly CLK_DIV cycles between them; every result is tagged ch7. Clear continuous → the current scan finishes, then IDLE.
5. Mid-scan disturbances: pulse start and change ch_mask to 8'hFF during a scan with mask 8'h03 → exactly 2 results (ch0, ch1); no restart.
6. Reset mid-scan: assert reset at bit 7 of frame 1 → CS_N=1 and SCLK=1 asynchronously with no further data_valid. A new start after release yields a correct full scan.

Source files
------------

// File: rtl/adc128s022_scan_ctrl.sv
// Multi-channel scan controller for the ADC128S022: walks the enabled channels in one
// CS-low burst, compensating for the ADC's one-frame address-to-data latency.
module adc128s022_scan_ctrl #(
  parameter int CLK_DIV = 8,
  parameter int N_CH    = 8,
  parameter int DATA_W  = 12
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              ADC_SDAT,
  output logic              ADC_SCLK,
  output logic              ADC_CS_N,
  output logic              ADC_SADDR,
  output logic [DATA_W-1:0] data_out,
  output logic [2:0]        data_ch,
  output logic              data_valid,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SCLK_LO, SCLK_HI, CS_HOLD} state_t;

  state_t            state, nxt;
  logic [7:0]        div_cnt;
  logic [3:0]        bit_cnt;
  logic [3:0]        frame_cnt;
  logic [3:0]        m_r;
  logic [N_CH-1:0]   mask_r;
  logic              cont_r;
  logic [2:0]        cur_ch;
  logic [2:0]        prev_ch;
  logic [DATA_W-1:0] shift;
  logic              div_done, latch, shift_en, bit_end, frame_end;

  function automatic logic [3:0] popcount(input logic [N_CH-1:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) c = c + 4'(m[i]);
    return c;
  endfunction

  function automatic logic [2:0] first_ch(input logic [N_CH-1:0] m);
    logic [2:0] r;
    logic       found;
    r = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && m[i]) begin
        r = 3'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Next enabled channel above cur; stays on cur when none is left, which yields
  // the repeated address of the trailing flush frame.
  function automatic logic [2:0] next_ch(input logic [N_CH-1:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic       found;
    r = cur;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && m[i] && (3'(i) > cur)) begin
        r = 3'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic addr_bit(input logic [2:0] ch, input logic [3:0] b);
    case (b)
      4'd2:    return ch[2];
      4'd3:    return ch[1];
      4'd4:    return ch[0];
      default: return 1'b0;
    endcase
  endfunction

  assign div_done  = (div_cnt == 8'(CLK_DIV - 1));
  assign frame_end = bit_end && (bit_cnt == 4'd15);
  assign ADC_SCLK  = (state != SCLK_LO);
  assign ADC_CS_N  = (state == IDLE) || (state == CS_HOLD);
  assign busy      = (state != IDLE);

  always_comb begin
    nxt      = state;
    latch    = 1'b0;
    shift_en = 1'b0;
    bit_end  = 1'b0;
    case (state)
      IDLE: begin
        if (start && (|ch_mask)) begin
          nxt   = CS_SETUP;
          latch = 1'b1;
        end
      end
      CS_SETUP: if (div_done) nxt = SCLK_LO;
      SCLK_LO: begin
        if (div_done) begin
          nxt      = SCLK_HI;
          shift_en = 1'b1;
        end
      end
      SCLK_HI: begin
        if (div_done) begin
          bit_end = 1'b1;
          nxt     = ((bit_cnt == 4'd15) && (frame_cnt == m_r)) ? CS_HOLD : SCLK_LO;
        end
      end
      CS_HOLD: begin
        if (div_done) begin
          if (cont_r && continuous && (|ch_mask)) begin
            nxt   = CS_SETUP;
            latch = 1'b1;
          end else begin
            nxt = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      frame_cnt  <= '0;
      m_r        <= '0;
      mask_r     <= '0;
      cont_r     <= 1'b0;
      cur_ch     <= '0;
      prev_ch    <= '0;
      shift      <= '0;
      ADC_SADDR  <= 1'b0;
      data_out   <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= nxt;
      div_cnt    <= ((nxt != state) || (state == IDLE)) ? 8'd0 : div_cnt + 8'd1;
      data_valid <= frame_end && (frame_cnt != 4'd0);
      if (latch) begin
        mask_r    <= ch_mask;
        m_r       <= popcount(ch_mask);
        cur_ch    <= first_ch(ch_mask);
        prev_ch   <= '0;
        bit_cnt   <= '0;
        frame_cnt <= '0;
        if (state == IDLE) cont_r <= continuous;
      end
      if (shift_en) shift <= {shift[DATA_W-2:0], ADC_SDAT};
      if (bit_end) bit_cnt <= bit_cnt + 4'd1;
      // Data clocked out in frame f belongs to the address sent in frame f-1.
      if (frame_end) begin
        frame_cnt <= frame_cnt + 4'd1;
        prev_ch   <= cur_ch;
        cur_ch    <= next_ch(mask_r, cur_ch);
        if (frame_cnt != 4'd0) begin
          data_out <= shift;
          data_ch  <= prev_ch;
        end
      end
      if ((nxt == SCLK_LO) && (state != SCLK_LO))
        ADC_SADDR <= ((state == SCLK_HI) && (bit_cnt != 4'd15)) ?
                     addr_bit(cur_ch, bit_cnt + 4'd1) : 1'b0;
    end
  end

endmodule
